// File: rtl/tt_check_pkg.sv
// Shared constants and FSM encoding for the truth-table response checker.
// Optional idle watchdog is enabled with the TT_CHECK_TIMEOUT_EN macro.
package tt_check_pkg;

    localparam int N_IN_DEF    = 3;
    localparam int CNT_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 64;

    // Majority-of-3: f = 1 when at least two of x, y, z are 1.
    localparam logic [7:0] MAJ3_TABLE = 8'b1110_1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tt_watchdog.sv
// Idle-cycle watchdog: counts consecutive running cycles without a kick and
// flags expiry on the cycle that would make the count reach TIMEOUT.
module tt_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    input  logic kick,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear || kick || !run) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // cnt_q holds the idle cycles already elapsed; this cycle is the TIMEOUT-th.
    assign expire = run && !kick && !clear && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/tt_response_checker.sv
// Response-side checker for exhaustive truth-table sweeps: compares dut_f with
// EXP_TABLE[vec_idx], tracks coverage, counts errors. Macro TT_CHECK_TIMEOUT_EN adds an idle watchdog.
module tt_response_checker
    import tt_check_pkg::*;
#(
    parameter int                    N_IN      = N_IN_DEF,
    parameter logic [(1<<N_IN)-1:0]  EXP_TABLE = MAJ3_TABLE,
    parameter int                    CNT_W     = CNT_W_DEF,
    parameter int                    TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 vec_valid,
    input  logic [N_IN-1:0]      vec_idx,
    input  logic                 dut_f,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 first_fail_vld,
    output logic [N_IN-1:0]      first_fail_idx,
    output logic [(1<<N_IN)-1:0] seen_mask,
    output logic                 timeout,
    output logic [1:0]           state_dbg
);

    localparam int NV = 1 << N_IN;

    // vec_valid has no backpressure: a sample is taken on every cycle it is high
    // while a run is active, and silently dropped in IDLE, DONE or under start.
    state_t          state_q, state_d;
    logic            sample;
    logic            mismatch;
    logic [NV-1:0]   seen_next;
    logic            cover_done;
    logic            wd_expire;
    logic            timeout_q;

    assign sample     = (state_q == ST_RUN) && vec_valid && !start;
    assign mismatch   = (dut_f != EXP_TABLE[vec_idx]);
    assign seen_next  = seen_mask | (NV'(1) << vec_idx);
    assign cover_done = sample && (&seen_next);

`ifdef TT_CHECK_TIMEOUT_EN
    tt_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (start),
        .run    (state_q == ST_RUN),
        .kick   (vec_valid),
        .expire (wd_expire)
    );
`else
    // No watchdog in this build; TIMEOUT is only meaningful with the feature on.
    assign wd_expire = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RUN:  if (cover_done || wd_expire) state_d = ST_DONE;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt        <= '0;
            seen_mask      <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
            timeout_q      <= 1'b0;
        end else if (start) begin
            err_cnt        <= '0;
            seen_mask      <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
            timeout_q      <= 1'b0;
        end else if (sample) begin
            seen_mask <= seen_next;
            if (mismatch) begin
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                if (!first_fail_vld) begin
                    first_fail_vld <= 1'b1;
                    first_fail_idx <= vec_idx;
                end
            end
        end else if (wd_expire) begin
            timeout_q <= 1'b1;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign timeout   = timeout_q;
    assign pass      = done && (err_cnt == '0) && !timeout_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_tt_response_checker.sv
// Self-checking bench for tt_response_checker with majority-of-3 expected table.
module tb_tt_response_checker;

    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       vec_valid;
    logic [2:0] vec_idx;
    logic       dut_f;
    logic       busy, done, pass, first_fail_vld, timeout;
    logic [7:0] err_cnt;
    logic [2:0] first_fail_idx;
    logic [7:0] seen_mask;
    logic [1:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    // Reference model: coverage set, run flags and a queue of mismatching vectors.
    bit         m_busy, m_done, m_to;
    bit [7:0]   m_seen;
    int         m_idle;
    logic [2:0] exp_q[$];

    tt_response_checker #(
        .N_IN      (3),
        .EXP_TABLE (8'b1110_1000),
        .CNT_W     (8),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .vec_valid      (vec_valid),
        .vec_idx        (vec_idx),
        .dut_f          (dut_f),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_fail_vld (first_fail_vld),
        .first_fail_idx (first_fail_idx),
        .seen_mask      (seen_mask),
        .timeout        (timeout),
        .state_dbg      (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic bit ref_f(input int idx);
        int ones;
        ones = ((idx >> 2) & 1) + ((idx >> 1) & 1) + (idx & 1);
        return (ones >= 2);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_to = 0; m_seen = '0; m_idle = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input bit s, input bit v, input int idx, input bit f);
        if (s) begin
            model_reset();
            m_busy = 1;
        end else if (m_busy && v) begin
            if (f != ref_f(idx)) exp_q.push_back(idx[2:0]);
            m_seen[idx] = 1'b1;
            m_idle = 0;
            if (m_seen == 8'hFF) begin
                m_busy = 0; m_done = 1;
            end
        end else if (m_busy) begin
            m_idle++;
`ifdef TT_CHECK_TIMEOUT_EN
            if (m_idle == TIMEOUT) begin
                m_to = 1; m_busy = 0; m_done = 1;
            end
`endif
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int e_err;
        e_err = (exp_q.size() > 255) ? 255 : exp_q.size();
        chk({tag, ".busy"},    32'(busy),           32'(m_busy));
        chk({tag, ".done"},    32'(done),           32'(m_done));
        chk({tag, ".pass"},    32'(pass),           32'(m_done && e_err == 0 && !m_to));
        chk({tag, ".err_cnt"}, 32'(err_cnt),        32'(e_err));
        chk({tag, ".ff_vld"},  32'(first_fail_vld), 32'(exp_q.size() > 0));
        chk({tag, ".ff_idx"},  32'(first_fail_idx), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
        chk({tag, ".seen"},    32'(seen_mask),      32'(m_seen));
        chk({tag, ".timeout"}, 32'(timeout),        32'(m_to));
    endtask

    task automatic step(input string tag, input bit s, input bit v, input int idx, input bit f);
        start = s; vec_valid = v; vec_idx = idx[2:0]; dut_f = f;
        @(posedge clk);
        #1;
        model_edge(s, v, idx, f);
        start = 0; vec_valid = 0;
        check_all(tag);
    endtask

    initial begin
        int perm[8];
        rst = 1; start = 0; vec_valid = 0; vec_idx = '0; dut_f = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.state", 32'(state_dbg), 32'd0);
        rst = 0;

        // vec_valid while IDLE is ignored
        step("idle_ign", 0, 1, 0, 1);

        // Clean sweep
        step("t1.start", 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step($sformatf("t1.v%0d", i), 0, 1, i, ref_f(i));
        step("t1.done_ign", 0, 1, 2, !ref_f(2));

        // Two mismatches at idx 3 and 5
        step("t2.start", 1, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            step($sformatf("t2.v%0d", i), 0, 1, i, (i == 3 || i == 5) ? 1'b0 : ref_f(i));

        // Duplicate idx 1, wrong on the repeat
        step("t3.start", 1, 0, 0, 0);
        step("t3.v0", 0, 1, 0, ref_f(0));
        step("t3.v1", 0, 1, 1, ref_f(1));
        step("t3.dup1", 0, 1, 1, !ref_f(1));
        for (int i = 2; i < 8; i++) step($sformatf("t3.v%0d", i), 0, 1, i, ref_f(i));

        // Restart collides with a sample, which is dropped
        step("t4.start", 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step($sformatf("t4.v%0d", i), 0, 1, i, !ref_f(i));
        step("t4.restart", 1, 1, 4, ref_f(4));

        // Async reset mid-run
        step("t5.start", 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step($sformatf("t5.v%0d", i), 0, 1, i, (i == 2) ? !ref_f(i) : ref_f(i));
        #1 rst = 1;
        #1;
        model_reset();
        check_all("t5.rst");
        #1 rst = 0;
        for (int i = 5; i < 8; i++) step($sformatf("t5.post%0d", i), 0, 1, i, ref_f(i));

        // Error counter saturation
        step("t6.start", 1, 0, 0, 0);
        for (int i = 0; i < 300; i++) step("t6.sat", 0, 1, 0, 1'b1);

        // Long idle gap: times out with the watchdog, keeps running without it
        step("t7.start", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step($sformatf("t7.v%0d", i), 0, 1, i, ref_f(i));
        for (int i = 0; i < TIMEOUT + 6; i++) step($sformatf("t7.idle%0d", i), 0, 0, 0, 0);
        step("t7.late", 0, 1, 3, ref_f(3));

        // Randomized sweeps: shuffled order, injected errors, duplicates, short gaps
        for (int r = 0; r < 25; r++) begin
            step("rnd.start", 1, 0, 0, 0);
            for (int i = 0; i < 8; i++) perm[i] = i;
            for (int i = 7; i > 0; i--) begin
                int j, t;
                j = $urandom_range(i, 0);
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            for (int i = 0; i < 8; i++) begin
                bit f;
                f = ref_f(perm[i]) ^ ($urandom_range(3, 0) == 0);
                if ($urandom_range(4, 0) == 0 && i > 0)
                    step("rnd.dup", 0, 1, perm[i-1], $urandom_range(1, 0) != 0);
                repeat ($urandom_range(2, 0)) step("rnd.gap", 0, 0, 0, 0);
                if (r % 7 == 6 && i == 4) step("rnd.restart", 1, 1, perm[i], f);
                step("rnd.v", 0, 1, perm[i], f);
            end
            step("rnd.tail", 0, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
